// File: rtl/lc4_phase_pkg.sv
// rtl/lc4_phase_pkg.sv - shared state type and width helpers for lc4_phase_gen
// Contents:
//   state_e      sequencer state (RUN, HALT)
//   clog2_min1   $clog2 clamped to a minimum of 1 bit
//   phase_width  width of the phase index (NUM_RE read phases + 1 write phase)
//   sub_width    width of the in-phase sub-counter (PHASE_LEN cycles)
package lc4_phase_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned phase_width(input int unsigned num_re);
    return clog2_min1(num_re + 1);
  endfunction

  function automatic int unsigned sub_width(input int unsigned phase_len);
    return clog2_min1(phase_len);
  endfunction

endpackage

// File: rtl/lc4_phase_counter.sv
// rtl/lc4_phase_counter.sv - mod-N counter with enable, clear and terminal count
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr_i    in   synchronous clear to 0 (wins over en_i)
//   en_i     in   advance by one, wrapping N-1 -> 0
//   count_o  out  current count (W bits)
//   tc_o     out  count == N-1
module lc4_phase_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o    = (cnt_q == W'(N - 1));
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc4_phase_gen.sv
// rtl/lc4_phase_gen.sv - LC4 read-enable / global-write-enable phase sequencer
// Optional feature macro: LC4_PHASE_STEP_EN (single-step HALT via step_mode/step_req).
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   stall       in   freeze the sequencer, suppress gwe
//   step_mode   in   halt after every gwe (macro builds only)
//   step_req    in   leave HALT (macro builds only)
//   re          out  one-hot read enables, re[0]=i1re re[1]=i2re re[2]=dre
//   gwe         out  global write enable, one cycle per processor cycle
//   phase       out  phase index of the presented cycle
//   halted      out  sequencer is in HALT
//   insn_count  out  gwe pulses since reset, wrapping
module lc4_phase_gen
  import lc4_phase_pkg::*;
#(
  parameter int unsigned NUM_RE    = 3,
  parameter int unsigned PHASE_LEN = 1,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         step_mode,
  input  logic                         step_req,
  output logic [NUM_RE-1:0]            re,
  output logic                         gwe,
  output logic [$clog2(NUM_RE+1)-1:0]  phase,
  output logic                         halted,
  output logic [WORD_SIZE-1:0]         insn_count
);

  localparam int unsigned PW = phase_width(NUM_RE);
  localparam int unsigned SW = sub_width(PHASE_LEN);

`ifdef LC4_PHASE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // The two counters hold the position that the NEXT edge will present,
  // so the registered outputs are a decode of the counters. Out of reset
  // that position is phase 0 / sub 0, which makes re[0] appear one cycle
  // after release with no extra start-up flag.
  logic [SW-1:0] sub_cnt;
  logic          sub_tc;
  logic [PW-1:0] ph_cnt;
  logic          ph_tc;
  logic          adv;
  logic          pos_clr;

  state_e                state_q,  state_d;
  logic [NUM_RE-1:0]     re_q,     re_d;
  logic                  gwe_q,    gwe_d;
  logic [PW-1:0]         phase_q,  phase_d;
  logic                  halted_q, halted_d;
  logic [WORD_SIZE-1:0]  count_q,  count_d;

  lc4_phase_counter #(
    .N (PHASE_LEN),
    .W (SW)
  ) u_sub (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pos_clr),
    .en_i    (adv),
    .count_o (sub_cnt),
    .tc_o    (sub_tc)
  );

  lc4_phase_counter #(
    .N (NUM_RE + 1),
    .W (PW)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pos_clr),
    .en_i    (adv & sub_tc),
    .count_o (ph_cnt),
    .tc_o    (ph_tc)
  );

  always_comb begin
    state_d  = state_q;
    re_d     = '0;
    gwe_d    = 1'b0;
    phase_d  = '0;
    halted_d = 1'b0;
    adv      = 1'b0;
    pos_clr  = 1'b0;
    // A presented gwe counts on the edge that ends it; stall cannot
    // retract a pulse that has already been driven.
    count_d  = count_q + WORD_SIZE'(gwe_q);

    unique case (state_q)
      ST_RUN: begin
        if (STEP_EN && gwe_q && step_mode) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          pos_clr  = 1'b1;
        end else begin
          phase_d = ph_cnt;
          re_d    = ph_tc ? '0 : (NUM_RE'(1) << ph_cnt);
          // Under stall the same position is presented with gwe masked and
          // the counters do not move, so the position is re-presented live
          // once stall drops.
          gwe_d   = ph_tc && sub_tc && !stall;
          adv     = !stall;
        end
      end
      ST_HALT: begin
        pos_clr  = 1'b1;
        halted_d = 1'b1;
        if (step_req) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        pos_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      re_q     <= '0;
      gwe_q    <= 1'b0;
      phase_q  <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      re_q     <= re_d;
      gwe_q    <= gwe_d;
      phase_q  <= phase_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign re         = re_q;
  assign gwe        = gwe_q;
  assign phase      = phase_q;
  assign halted     = halted_q;
  assign insn_count = count_q;

endmodule

// File: tb/tb_lc4_phase_gen.sv
// tb/tb_lc4_phase_gen.sv - self-checking bench for lc4_phase_gen (three configurations)
module tb_lc4_phase_gen;

`ifdef LC4_PHASE_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  localparam int NR  [3] = '{3, 2, 3};
  localparam int LEN [3] = '{1, 3, 2};
  localparam int WS  [3] = '{16, 16, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic step_mode = 1'b0;
  logic step_req = 1'b0;

  logic [2:0]  re0;  logic gwe0; logic [1:0] ph0; logic hl0; logic [15:0] cnt0;
  logic [1:0]  re1;  logic gwe1; logic [1:0] ph1; logic hl1; logic [15:0] cnt1;
  logic [2:0]  re2;  logic gwe2; logic [1:0] ph2; logic hl2; logic [3:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  lc4_phase_gen #(.NUM_RE(3), .PHASE_LEN(1), .WORD_SIZE(16)) d0 (
    .clk(clk), .rst(rst), .stall(stall), .step_mode(step_mode), .step_req(step_req),
    .re(re0), .gwe(gwe0), .phase(ph0), .halted(hl0), .insn_count(cnt0));
  lc4_phase_gen #(.NUM_RE(2), .PHASE_LEN(3), .WORD_SIZE(16)) d1 (
    .clk(clk), .rst(rst), .stall(stall), .step_mode(step_mode), .step_req(step_req),
    .re(re1), .gwe(gwe1), .phase(ph1), .halted(hl1), .insn_count(cnt1));
  lc4_phase_gen #(.NUM_RE(3), .PHASE_LEN(2), .WORD_SIZE(4)) d2 (
    .clk(clk), .rst(rst), .stall(stall), .step_mode(step_mode), .step_req(step_req),
    .re(re2), .gwe(gwe2), .phase(ph2), .halted(hl2), .insn_count(cnt2));

  // Reference: a processor cycle is a linear index 0..(NUM_RE+1)*PHASE_LEN-1
  // of the next cycle to present; phase = index / PHASE_LEN.
  int          m_pos   [3];
  bit          m_halt  [3];
  int          m_re    [3];
  bit          m_gwe   [3];
  int          m_phase [3];
  bit          m_hd    [3];
  int unsigned m_cnt   [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int per;
      int ph;
      per = (NR[i] + 1) * LEN[i];
      if (rst) begin
        m_pos[i] = 0; m_halt[i] = 0; m_re[i] = 0; m_gwe[i] = 0;
        m_phase[i] = 0; m_hd[i] = 0; m_cnt[i] = 0;
      end else begin
        if (m_gwe[i]) m_cnt[i] = (m_cnt[i] + 1) % (32'd1 << WS[i]);
        if (m_halt[i]) begin
          m_re[i] = 0; m_gwe[i] = 0; m_phase[i] = 0;
          if (step_req) begin m_halt[i] = 0; m_hd[i] = 0; end
          else m_hd[i] = 1;
        end else if (m_gwe[i] && STEP && step_mode) begin
          m_halt[i] = 1; m_hd[i] = 1; m_re[i] = 0; m_gwe[i] = 0;
          m_phase[i] = 0; m_pos[i] = 0;
        end else begin
          ph = m_pos[i] / LEN[i];
          m_phase[i] = ph;
          m_re[i] = (ph < NR[i]) ? (1 << ph) : 0;
          m_gwe[i] = (m_pos[i] == per - 1) && !stall;
          m_hd[i] = 0;
          if (!stall) m_pos[i] = (m_pos[i] + 1) % per;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input int i, input int r, input int g, input int p, input int h, input int c);
    chk($sformatf("d%0d.re", i), r, m_re[i]);
    chk($sformatf("d%0d.gwe", i), g, int'(m_gwe[i]));
    chk($sformatf("d%0d.phase", i), p, m_phase[i]);
    chk($sformatf("d%0d.halted", i), h, int'(m_hd[i]));
    chk($sformatf("d%0d.insn_count", i), c, int'(m_cnt[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, int'(re0), int'(gwe0), int'(ph0), int'(hl0), int'(cnt0));
      cmp(1, int'(re1), int'(gwe1), int'(ph1), int'(hl1), int'(cnt1));
      cmp(2, int'(re2), int'(gwe2), int'(ph2), int'(hl2), int'(cnt2));
    end
  end

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int gwe_seen;
    bit found;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset.re", int'(re0), 0);
    chk("reset.insn_count", int'(cnt0), 0);

    // Free run: default pattern, NUM_RE=2/PHASE_LEN=3 pattern, counts and 4-bit wrap.
    do_reset();
    for (int k = 1; k <= 137; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        chk("run.d0.re", int'(re0), (k % 4 == 0) ? 0 : (1 << ((k % 4) - 1)));
        chk("run.d0.gwe", int'(gwe0), int'(k % 4 == 0));
      end
      if (k <= 9) begin
        chk("run.d1.re", int'(re1), (k <= 3) ? 1 : (k <= 6) ? 2 : 0);
        chk("run.d1.gwe", int'(gwe1), int'(k == 9));
      end
      if (k == 13)  chk("run.d0.count12", int'(cnt0), 3);
      if (k == 128) chk("wrap.d2.count15", int'(cnt2), 15);
      if (k == 129) chk("wrap.d2.count0", int'(cnt2), 0);
      if (k == 137) begin
        chk("wrap.d2.count1", int'(cnt2), 1);
        chk("run.d0.count137", int'(cnt0), 34);
        chk("run.d1.count137", int'(cnt1), 15);
      end
    end

    // Stall for five edges starting where gwe would be presented.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 4 && k <= 8) begin
        chk("stall.d0.phase", int'(ph0), 3);
        chk("stall.d0.gwe", int'(gwe0), 0);
        chk("stall.d0.count", int'(cnt0), 0);
      end
      if (k == 9)  chk("stall.d0.gwe_after", int'(gwe0), 1);
      if (k == 10) begin
        chk("stall.d0.count_once", int'(cnt0), 1);
        chk("stall.d0.re_restart", int'(re0), 1);
      end
      if (k == 3) stall = 1'b1;
      if (k == 8) stall = 1'b0;
    end

    // Single step.
    do_reset();
    step_mode = 1'b1;
    gwe_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (STEP) begin
        if (k == 4) chk("step.d0.first_gwe", int'(gwe0), 1);
        if (k >= 5 && k <= 24) begin
          chk("step.d0.halted", int'(hl0), 1);
          chk("step.d0.re_halt", int'(re0), 0);
          chk("step.d0.gwe_halt", int'(gwe0), 0);
        end
        if (k == 25) chk("step.d0.exit", int'(hl0), 0);
        if (k == 26) chk("step.d0.re0", int'(re0), 1);
        if (k >= 25 && gwe0) gwe_seen++;
        if (k >= 30) chk("step.d0.rehalt", int'(hl0), 1);
        if (k == 24) step_req = 1'b1;
        if (k == 25) step_req = 1'b0;
      end else begin
        if (k == 5) begin
          chk("nostep.d0.halted", int'(hl0), 0);
          chk("nostep.d0.re", int'(re0), 1);
        end
        if (k == 24) step_req = 1'b1;
        if (k == 25) step_req = 1'b0;
      end
    end
    if (STEP) chk("step.d0.one_period", gwe_seen, 1);

    // Reset in the middle of phase 1 with insn_count at 0x00FF.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 1300 && !found; k++) begin
      @(negedge clk);
      if (m_cnt[0] == 255 && m_phase[0] == 1) found = 1'b1;
    end
    chk("midrst.reached", int'(found), 1);
    chk("midrst.d0.count_ff", int'(cnt0), 255);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.d0.re", int'(re0), 0);
    chk("midrst.d0.phase", int'(ph0), 0);
    chk("midrst.d0.count", int'(cnt0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.d0.restart", int'(re0), 1);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      stall     = ($urandom % 4) == 0;
      step_mode = ($urandom % 2) == 0;
      step_req  = ($urandom % 8) == 0;
      rst       = ($urandom % 200) == 0;
    end
    rst = 1'b0; stall = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
